// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NPC_*       : next-PC select encodings, the same values the controller drives
//                 on NPCOp. Each non-plus4 encoding is one-hot, so the selector
//                 tests individual bits.
//   WORD_MASK   : low address bits that must be zero for a word fetch.
//   opcode_of / funct3_of / funct7_of : return the decoder fields of an instruction word.
package if_fetch_unit_pkg;

  localparam logic [2:0]  NPC_PLUS4  = 3'b000;
  localparam logic [2:0]  NPC_BRANCH = 3'b001;
  localparam logic [2:0]  NPC_JUMP   = 3'b010;
  localparam logic [2:0]  NPC_JALR   = 3'b100;

  localparam logic [31:0] WORD_MASK  = 32'h0000_0003;

  function automatic logic [6:0] opcode_of(input logic [31:0] ins);
    return ins[6:0];
  endfunction

  function automatic logic [2:0] funct3_of(input logic [31:0] ins);
    return ins[14:12];
  endfunction

  function automatic logic [6:0] funct7_of(input logic [31:0] ins);
    return ins[31:25];
  endfunction

endpackage

// File: rtl/if_fetch_unit_npc.sv
// npc_calc: purely combinational next-PC selector.
//   pc, imm, alu_result : 32-bit operands (the current PC, the extended immediate, the jalr sum)
//   npc_op              : NPCOp select, priority jalr > jal > branch > plus4
//   target              : selected next PC (all sums wrap at 32 bits)
//   misaligned          : target is not word-aligned
module npc_calc
  import if_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic [2:0]  npc_op,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] pc_imm;
  logic [31:0] pc_inc;

  assign pc_imm = pc + imm;
  assign pc_inc = pc + 32'd4;

  // Bit tests rather than a full-value case so that multi-hot or undefined
  // selects still resolve to exactly one target.
  always_comb begin
    target = pc_inc;
    if (|(npc_op & NPC_JALR))        target = alu_result & ~32'h1;
    else if (|(npc_op & NPC_JUMP))   target = pc_imm;
    else if (|(npc_op & NPC_BRANCH)) target = pc_imm;
  end

  assign misaligned = |(target & WORD_MASK);

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: multi-cycle fetch stage (FETCH -> WAIT -> EXEC, HALT on a bad PC).
//   clk, rst                       : clock, asynchronous active-high reset
//   imem_req_valid/addr/ready      : word-read request channel (addr == pc)
//   imem_rsp_valid/data            : read response, sampled only in WAIT
//   instr, instr_valid             : instruction register and its execute strobe
//   pc, pc_plus4                   : PC of instr and its link value
//   NPCOp, imm, alu_result         : next-PC select and operands from the decoder/ALU
//   ex_stall                       : hold the current instruction in EXEC
//   instret                        : retired-instruction count (wraps)
//   misalign_err, halt             : sticky misaligned-target flag and halted state
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        ex_stall,
  output logic [31:0] instret,
  output logic        misalign_err,
  output logic        halt
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        misalign_q, misalign_d;
  logic        req_valid_q, req_valid_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halt_q, halt_d;

  logic [31:0] target;
  logic        target_misaligned;

  npc_calc u_npc (
    .pc         (pc_q),
    .imm        (imm),
    .alu_result (alu_result),
    .npc_op     (NPCOp),
    .target     (target),
    .misaligned (target_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instret_d  = instret_q;
    misalign_d = misalign_q;
    case (state_q)
      // req_valid_q gates acceptance so nothing is taken in the reset-release cycle.
      FETCH: if (req_valid_q && imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ex_stall) begin
          if (target_misaligned) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d      = target;
            instret_d = instret_q + 32'd1;
            state_d   = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // Strobes are decoded from the next state so they come straight from flops.
    req_valid_d   = (state_d == FETCH);
    instr_valid_d = (state_d == EXEC);
    halt_d        = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instret_q     <= 32'd0;
      misalign_q    <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      misalign_q    <= misalign_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      halt_q        <= halt_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign instret        = instret_q;
  assign misalign_err   = misalign_q;
  assign halt           = halt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small instruction-memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  NPCOp;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        ex_stall;
  logic [31:0] instret;
  logic        misalign_err;
  logic        halt;

  if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .NPCOp(NPCOp), .imm(imm),
    .alu_result(alu_result), .ex_stall(ex_stall), .instret(instret),
    .misalign_err(misalign_err), .halt(halt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory model state
  logic        pending, accept_nxt, inject_rsp;
  logic [31:0] p_addr, acc_addr;
  int          p_cnt, rsp_delay, ready_hold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Responds rsp_delay cycles after the cycle following acceptance; drops
  // everything on reset.
  task automatic mem_model();
    if (rst) begin
      pending = 1'b0; accept_nxt = 1'b0;
      imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    end else begin
      if (accept_nxt) begin
        pending = 1'b1; p_addr = acc_addr; p_cnt = rsp_delay;
      end
      accept_nxt = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (pending) begin
        if (p_cnt == 0) begin
          imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(p_addr); pending = 1'b0;
        end else p_cnt--;
      end
      if (inject_rsp) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; inject_rsp = 1'b0;
      end
      if (imem_req_valid && ready_hold != 0) begin
        imem_req_ready = 1'b0; ready_hold--;
      end else imem_req_ready = 1'b1;
      if (imem_req_valid && imem_req_ready) begin
        accept_nxt = 1'b1; acc_addr = imem_req_addr;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    mem_model();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 40) begin step(); n++; end
    if (!imem_req_valid) chk("req_timeout", {31'h0, imem_req_valid}, 32'h1);
  endtask

  task automatic wait_exec();
    int n = 0;
    while (!instr_valid && n < 40) begin step(); n++; end
    if (!instr_valid) chk("exec_timeout", {31'h0, instr_valid}, 32'h1);
  endtask

  int f_cyc, prev_f;

  initial begin
    rst = 1'b1; NPCOp = 3'b000; imm = 32'h0; alu_result = 32'h0; ex_stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    pending = 1'b0; accept_nxt = 1'b0; inject_rsp = 1'b0;
    p_addr = 32'h0; acc_addr = 32'h0; p_cnt = 0; rsp_delay = 0; ready_hold = 0;

    // reset state
    step(); step();
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_halt", {31'h0, halt}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_instret", instret, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
    rst = 1'b0;
    step();
    chk("req_first_cycle", {31'h0, imem_req_valid}, 32'h1);

    // sequential fetches 0,4,8,C every 3 cycles
    prev_f = 0;
    for (int k = 0; k < 4; k++) begin
      wait_req();
      chk("seq_addr", imem_req_addr, 32'(4 * k));
      chk("seq_instret", instret, 32'(k));
      if (k > 0) chk("seq_period", 32'(cyc - prev_f), 32'd3);
      prev_f = cyc;
      wait_exec();
      chk("seq_instr", instr, mem_word(32'(4 * k)));
      chk("seq_pc_plus4", pc_plus4, 32'(4 * k + 4));
    end

    // ready low 4 cycles at 0x10, stray response while in FETCH
    ready_hold = 4;
    wait_req();
    f_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      chk("hold_addr", imem_req_addr, 32'h10);
      chk("hold_valid", {31'h0, imem_req_valid}, 32'h1);
      if (i == 0) inject_rsp = 1'b1;
      step();
    end
    wait_exec();
    chk("hold_exec_lat", 32'(cyc - f_cyc), 32'd6);
    chk("hold_instr", instr, mem_word(32'h10));

    // run on to 0x20
    for (int a = 0; a < 3; a++) begin wait_req(); wait_exec(); end
    wait_req();
    chk("pre_br_addr", imem_req_addr, 32'h20);

    // branch back, then jal forward
    NPCOp = 3'b001; imm = 32'hFFFF_FFF0;
    wait_exec();
    chk("br_pc", pc, 32'h20);
    wait_req();
    chk("br_target", imem_req_addr, 32'h10);
    chk("br_instret", instret, 32'd9);
    NPCOp = 3'b010; imm = 32'h100;
    wait_exec();
    wait_req();
    chk("jal_target", imem_req_addr, 32'h110);
    chk("jal_instret", instret, 32'd10);

    // execute stall
    NPCOp = 3'b000; ex_stall = 1'b1;
    wait_exec();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc", pc, 32'h110);
      chk("stall_instret", instret, 32'd10);
      chk("stall_instr", instr, mem_word(32'h110));
      step();
    end
    ex_stall = 1'b0;
    wait_req();
    chk("stall_next", imem_req_addr, 32'h114);
    chk("stall_instret_inc", instret, 32'd11);

    // jalr clears the LSB
    NPCOp = 3'b100; alu_result = 32'h0000_0301;
    wait_exec();
    wait_req();
    chk("jalr_target", imem_req_addr, 32'h300);
    // multi-hot: jalr wins
    NPCOp = 3'b111; imm = 32'h40; alu_result = 32'h0000_0501;
    wait_exec();
    wait_req();
    chk("multihot_target", imem_req_addr, 32'h500);
    chk("multihot_instret", instret, 32'd13);

    // misaligned jalr -> HALT
    NPCOp = 3'b100; alu_result = 32'h0000_0207;
    wait_exec();
    step();
    chk("mis_halt", {31'h0, halt}, 32'h1);
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_pc", pc, 32'h500);
    chk("mis_instret", instret, 32'd13);
    for (int i = 0; i < 4; i++) begin
      chk("halt_no_req", {31'h0, imem_req_valid}, 32'h0);
      chk("halt_no_exec", {31'h0, instr_valid}, 32'h0);
      step();
    end
    chk("halt_stays", {31'h0, halt}, 32'h1);

    // reset out of HALT
    rst = 1'b1;
    step();
    chk("rst2_halt", {31'h0, halt}, 32'h0);
    chk("rst2_err", {31'h0, misalign_err}, 32'h0);
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_instret", instret, 32'h0);
    rst = 1'b0; NPCOp = 3'b000; rsp_delay = 3;

    // reset mid-WAIT, then a stray late response
    wait_req();
    step();
    chk("midwait_req", {31'h0, imem_req_valid}, 32'h0);
    chk("midwait_exec", {31'h0, instr_valid}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0; inject_rsp = 1'b1; rsp_delay = 0;
    step();
    chk("late_req", {31'h0, imem_req_valid}, 32'h1);
    chk("late_pc", pc, 32'h0);
    step();
    chk("late_instr_nop", instr, 32'h0000_0013);
    chk("late_no_exec", {31'h0, instr_valid}, 32'h0);
    wait_exec();
    chk("refetch_instr", instr, mem_word(32'h0));
    chk("refetch_pc", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
